// File: rtl/key_remap_ctrl.sv
// Debounced 5-button input with a runtime-programmable physical-to-logical key map.
// A remap session captures one distinct physical press per logical key W,A,S,D,E in order.
module key_remap_ctrl #(
    parameter int DB_CNT = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] btn_raw,
    input  logic       start,
    input  logic       abort,
    output logic [4:0] key_out,
    output logic       remap_busy,
    output logic [2:0] remap_step,
    output logic       map_valid,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, WAIT_REL, CAPTURE, COMMIT} state_t;

    localparam logic [19:0] DB_LAST = 20'(DB_CNT - 1);

    logic [4:0]  sync1_r, sync2_r, db_r, db_d_r;
    logic [19:0] cnt_r [5];
    logic [2:0]  map_r [5];
    logic [2:0]  shadow_r [5];
    logic [4:0]  used_r;
    logic [2:0]  step_r;
    state_t      state_r;
    logic [4:0]  key_out_r;
    logic        remap_busy_r, map_valid_r, err_r;
    logic [2:0]  remap_step_r;

    logic [4:0]  pr_s, keys_s;
    logic [2:0]  pr_idx_s;
    logic        capture_ok_s;

    function automatic logic is_onehot(input logic [4:0] v);
        return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
    endfunction

    function automatic logic [2:0] encode(input logic [4:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int p = 4; p >= 0; p--) begin
            if (v[p]) begin
                idx = 3'(p);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Input synchronizers, per-button debounce counters and press-edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 5'd0;
            sync2_r <= 5'd0;
            db_r    <= 5'd0;
            db_d_r  <= 5'd0;
            for (int p = 0; p < 5; p++) cnt_r[p] <= 20'd0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
            db_d_r  <= db_r;
            for (int p = 0; p < 5; p++) begin
                if (sync2_r[p] != db_r[p]) begin
                    if (cnt_r[p] == DB_LAST) begin
                        db_r[p]  <= sync2_r[p];
                        cnt_r[p] <= 20'd0;
                    end else begin
                        cnt_r[p] <= cnt_r[p] + 20'd1;
                    end
                end else begin
                    cnt_r[p] <= 20'd0;
                end
            end
        end
    end

    // Press pulses, capture legality and the remapped key vector
    always_comb begin
        pr_s         = db_r & ~db_d_r;
        pr_idx_s     = encode(pr_s);
        capture_ok_s = is_onehot(pr_s) && ((pr_s & used_r) == 5'd0);
        keys_s       = 5'd0;
        for (int i = 0; i < 5; i++) begin
            case (map_r[i])
                3'd0:    keys_s[i] = db_r[0];
                3'd1:    keys_s[i] = db_r[1];
                3'd2:    keys_s[i] = db_r[2];
                3'd3:    keys_s[i] = db_r[3];
                3'd4:    keys_s[i] = db_r[4];
                default: keys_s[i] = 1'b0;
            endcase
        end
    end

    // Remap session FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            used_r       <= 5'd0;
            step_r       <= 3'd0;
            key_out_r    <= 5'd0;
            remap_busy_r <= 1'b0;
            remap_step_r <= 3'd0;
            map_valid_r  <= 1'b0;
            err_r        <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                map_r[i]    <= 3'(i);
                shadow_r[i] <= 3'(i);
            end
        end else begin
            map_valid_r <= 1'b0;
            err_r       <= 1'b0;
            key_out_r   <= (state_r == IDLE) ? keys_s : 5'd0;
            case (state_r)
                IDLE: begin
                    remap_step_r <= 3'd0;
                    if (start) begin
                        state_r      <= WAIT_REL;
                        remap_busy_r <= 1'b1;
                    end else begin
                        remap_busy_r <= 1'b0;
                    end
                end
                WAIT_REL: begin
                    remap_step_r <= 3'd0;
                    if (abort) begin
                        state_r      <= IDLE;
                        remap_busy_r <= 1'b0;
                    end else if (db_r == 5'd0) begin
                        state_r <= CAPTURE;
                        step_r  <= 3'd0;
                        used_r  <= 5'd0;
                    end
                end
                CAPTURE: begin
                    if (abort) begin
                        state_r      <= IDLE;
                        remap_busy_r <= 1'b0;
                        remap_step_r <= 3'd0;
                    end else if (pr_s != 5'd0) begin
                        if (capture_ok_s) begin
                            for (int i = 0; i < 5; i++) begin
                                if (step_r == 3'(i)) shadow_r[i] <= pr_idx_s;
                            end
                            used_r <= used_r | pr_s;
                            if (step_r == 3'd4) begin
                                state_r      <= COMMIT;
                                remap_step_r <= 3'd0;
                            end else begin
                                step_r       <= step_r + 3'd1;
                                remap_step_r <= step_r + 3'd1;
                            end
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    // abort is deliberately not consulted: a completed capture always lands
                    for (int i = 0; i < 5; i++) map_r[i] <= shadow_r[i];
                    map_valid_r  <= 1'b1;
                    remap_busy_r <= 1'b0;
                    remap_step_r <= 3'd0;
                    state_r      <= IDLE;
                end
                default: begin
                    state_r      <= IDLE;
                    remap_busy_r <= 1'b0;
                    remap_step_r <= 3'd0;
                end
            endcase
        end
    end

    assign key_out    = key_out_r;
    assign remap_busy = remap_busy_r;
    assign remap_step = remap_step_r;
    assign map_valid  = map_valid_r;
    assign err        = err_r;

endmodule

// File: tb/tb_key_remap_ctrl.sv
// Directed self-checking bench for key_remap_ctrl with a 4-cycle debounce window.
module tb_key_remap_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, start, abort;
    logic [4:0] btn_raw;
    logic [4:0] key_out;
    logic       remap_busy, map_valid, err;
    logic [2:0] remap_step;

    int n_cmp  = 0;
    int n_fail = 0;
    int mv_cnt = 0;
    int err_cnt = 0;

    key_remap_ctrl #(.DB_CNT(4)) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .start(start), .abort(abort),
        .key_out(key_out), .remap_busy(remap_busy), .remap_step(remap_step),
        .map_valid(map_valid), .err(err)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle
    always @(posedge clk) begin
        #2;
        if (map_valid === 1'b1) mv_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [4:0] m);
        btn_raw = m;
        cycles(10);
        btn_raw = 5'd0;
        cycles(10);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycles(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; btn_raw = 5'd0;
        cycles(2);
        n_cmp++;
        if ({key_out, remap_busy, remap_step, map_valid, err} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outs: got %b expected 0", {key_out, remap_busy, remap_step, map_valid, err});
        end
        rst_n = 1'b1;
        cycles(1);
    endtask

    task automatic test_debounce();
        logic bad;
        btn_raw = 5'b00100;
        cycles(6);
        n_cmp++;
        if (key_out !== 5'b00000) begin n_fail++; $display("FAIL db_early: got %b expected 00000", key_out); end
        cycles(1);
        n_cmp++;
        if (key_out !== 5'b00100) begin n_fail++; $display("FAIL db_rise: got %b expected 00100", key_out); end
        cycles(3);
        btn_raw = 5'd0;
        cycles(10);
        n_cmp++;
        if (key_out !== 5'b00000) begin n_fail++; $display("FAIL db_release: got %b expected 00000", key_out); end
        btn_raw = 5'b00010;
        cycles(3);
        btn_raw = 5'd0;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            if (key_out !== 5'b00000) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin n_fail++; $display("FAIL db_glitch: got key change expected none"); end
    endtask

    task automatic test_remap();
        int mv0;
        logic [4:0] m;
        mv0 = mv_cnt;
        pulse_start();
        n_cmp++;
        if (remap_busy !== 1'b1) begin n_fail++; $display("FAIL remap_busy_on: got %b expected 1", remap_busy); end
        cycles(2);
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (remap_step !== 3'(k)) begin n_fail++; $display("FAIL remap_step: got %0d expected %0d", remap_step, k); end
            m = 5'b00001 << (4 - k);
            press(m);
        end
        n_cmp++;
        if (mv_cnt - mv0 != 1) begin n_fail++; $display("FAIL map_valid_pulses: got %0d expected 1", mv_cnt - mv0); end
        n_cmp++;
        if (remap_busy !== 1'b0 || remap_step !== 3'd0) begin
            n_fail++; $display("FAIL remap_done: got busy=%b step=%0d expected 0/0", remap_busy, remap_step);
        end
        btn_raw = 5'b00001;
        cycles(8);
        n_cmp++;
        if (key_out !== 5'b10000) begin n_fail++; $display("FAIL remap_key0: got %b expected 10000", key_out); end
        btn_raw = 5'b10000;
        cycles(8);
        n_cmp++;
        if (key_out !== 5'b00001) begin n_fail++; $display("FAIL remap_key4: got %b expected 00001", key_out); end
        btn_raw = 5'd0;
        cycles(10);
    endtask

    task automatic test_err_abort();
        int e0, m0;
        e0 = err_cnt; m0 = mv_cnt;
        pulse_start();
        cycles(2);
        press(5'b10000);
        press(5'b01000);
        n_cmp++;
        if (remap_step !== 3'd2) begin n_fail++; $display("FAIL err_pre_step: got %0d expected 2", remap_step); end
        press(5'b10000);
        n_cmp++;
        if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL err_used: got %0d expected 1", err_cnt - e0); end
        n_cmp++;
        if (remap_step !== 3'd2) begin n_fail++; $display("FAIL err_used_step: got %0d expected 2", remap_step); end
        press(5'b00011);
        n_cmp++;
        if (err_cnt - e0 != 2) begin n_fail++; $display("FAIL err_multi: got %0d expected 2", err_cnt - e0); end
        n_cmp++;
        if (remap_step !== 3'd2) begin n_fail++; $display("FAIL err_multi_step: got %0d expected 2", remap_step); end
        press(5'b00100);
        n_cmp++;
        if (remap_step !== 3'd3) begin n_fail++; $display("FAIL abort_pre_step: got %0d expected 3", remap_step); end
        abort = 1'b1;
        cycles(1);
        abort = 1'b0;
        n_cmp++;
        if (remap_busy !== 1'b0 || remap_step !== 3'd0) begin
            n_fail++; $display("FAIL abort_idle: got busy=%b step=%0d expected 0/0", remap_busy, remap_step);
        end
        cycles(2);
        n_cmp++;
        if (mv_cnt != m0) begin n_fail++; $display("FAIL abort_no_commit: got %0d expected %0d", mv_cnt, m0); end
        btn_raw = 5'b00001;
        cycles(8);
        n_cmp++;
        if (key_out !== 5'b10000) begin n_fail++; $display("FAIL abort_map_kept: got %b expected 10000", key_out); end
        btn_raw = 5'd0;
        cycles(10);
    endtask

    task automatic test_start_held();
        btn_raw = 5'b01000;
        cycles(10);
        pulse_start();
        n_cmp++;
        if (remap_busy !== 1'b1 || remap_step !== 3'd0) begin
            n_fail++; $display("FAIL held_start: got busy=%b step=%0d expected 1/0", remap_busy, remap_step);
        end
        btn_raw = 5'b01001;
        cycles(10);
        n_cmp++;
        if (remap_busy !== 1'b1 || remap_step !== 3'd0) begin
            n_fail++; $display("FAIL held_no_capture: got busy=%b step=%0d expected 1/0", remap_busy, remap_step);
        end
        btn_raw = 5'd0;
        cycles(10);
        press(5'b00001);
        n_cmp++;
        if (remap_step !== 3'd1) begin n_fail++; $display("FAIL held_after_release: got %0d expected 1", remap_step); end
        abort = 1'b1;
        cycles(1);
        abort = 1'b0;
        cycles(2);
        n_cmp++;
        if (remap_busy !== 1'b0) begin n_fail++; $display("FAIL held_abort: got %b expected 0", remap_busy); end
    endtask

    task automatic test_reset_mid();
        int m0;
        m0 = mv_cnt;
        pulse_start();
        cycles(2);
        press(5'b10000);
        press(5'b01000);
        n_cmp++;
        if (remap_step !== 3'd2) begin n_fail++; $display("FAIL rstmid_step: got %0d expected 2", remap_step); end
        btn_raw = 5'b00100;
        cycles(3);
        rst_n = 1'b0;
        cycles(1);
        n_cmp++;
        if ({key_out, remap_busy, remap_step, map_valid, err} !== 11'd0) begin
            n_fail++;
            $display("FAIL rstmid_outs: got %b expected 0", {key_out, remap_busy, remap_step, map_valid, err});
        end
        btn_raw = 5'd0;
        cycles(1);
        rst_n = 1'b1;
        cycles(2);
        btn_raw = 5'b00001;
        cycles(8);
        n_cmp++;
        if (key_out !== 5'b00001 || mv_cnt != m0) begin
            n_fail++; $display("FAIL rstmid_identity: got key=%b mv=%0d expected 00001 mv=%0d", key_out, mv_cnt, m0);
        end
        btn_raw = 5'd0;
        cycles(10);
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_remap();
        test_err_abort();
        test_start_held();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
